// File: rtl/fc_layer_stream.sv
`timescale 1ns/1ps
// fc_layer_stream
// Streaming fully-connected layer: y[n] = act(sat(sum_m W[n][m] * x[m])).
// A vector of M signed words is collected on the slave stream. The N outputs
// are then computed in N/P groups of P lanes. Each group runs M MAC cycles and
// one saturation cycle, then its P results are emitted in order on the master
// stream. Weights are a read-only table supplied through the packed parameter
// W_INIT, with W[n][m] held at bits [(n*M+m)*T +: T].
//
// Ports:
//   clk      clock
//   reset    asynchronous, active-high reset
//   s_valid  input word valid
//   s_ready  block can accept an input word (LOAD only)
//   data_in  signed input word x[m], m ascending
//   m_valid  output word valid
//   m_ready  downstream ready for output
//   data_out signed output word y[n], n ascending
module fc_layer_stream #(
    parameter int T    = 16,
    parameter int M    = 4,
    parameter int N    = 8,
    parameter int P    = 2,
    parameter int RELU = 1,
    parameter logic [N*M*T-1:0] W_INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    input  logic         m_ready,
    input  logic [T-1:0] data_in,
    output logic         m_valid,
    output logic         s_ready,
    output logic [T-1:0] data_out
);

    // Accumulator is wide enough to hold M full-precision products without overflow.
    localparam int AW = 2 * T + $clog2(M);
    localparam int G  = N / P;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int EW = (P > 1) ? $clog2(P) : 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'({1'b0, {(T-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    if ((N % P) != 0) begin : g_bad_lanes
        $error("fc_layer_stream: N must be a multiple of P");
    end

    typedef enum logic [1:0] {LOAD, MAC, SAT, EMIT} state_t;

    state_t state, state_next;

    logic [CW-1:0] cnt;
    logic [CW-1:0] k;
    logic [GW-1:0] g;
    logic [EW-1:0] e;

    logic signed [T-1:0]    x_mem   [M];
    logic signed [AW-1:0]   acc     [P];
    logic signed [T-1:0]    out_buf [P];
    logic signed [T-1:0]    w_lane  [P];
    logic signed [2*T-1:0]  prod    [P];
    logic signed [T-1:0]    sat_val [P];

    logic accept;
    logic last_in;
    logic last_k;
    logic last_e;
    logic last_g;
    logic out_xfer;

    // s_ready is also held low while reset is asserted, so the first
    // acceptance can only happen after reset is released.
    assign s_ready  = (state == LOAD) && !reset;
    assign accept   = s_valid && s_ready;
    assign last_in  = (cnt == CW'(M - 1));
    assign last_k   = (k == CW'(M - 1));
    assign last_e   = (e == EW'(P - 1));
    assign last_g   = (g == GW'(G - 1));
    assign out_xfer = m_valid && m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD: if (accept && last_in) state_next = MAC;
            MAC:  if (last_k) state_next = SAT;
            SAT:  state_next = EMIT;
            EMIT: if (out_xfer && last_e) state_next = last_g ? LOAD : MAC;
            default: state_next = LOAD;
        endcase
    end

    // Lane p of group g works on output row g*P+p; the weight is picked
    // combinationally from the table for the current input index k.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_lane[p] = W_INIT[(((int'(g) * P) + p) * M + int'(k)) * T +: T];
            prod[p]   = (2*T)'(x_mem[k]) * (2*T)'(w_lane[p]);
        end
    end

    // Clip to the T-bit signed range first, then optionally zero negatives.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            if (acc[p] > SAT_MAX) begin
                sat_val[p] = SAT_MAX[T-1:0];
            end else if (acc[p] < SAT_MIN) begin
                sat_val[p] = SAT_MIN[T-1:0];
            end else begin
                sat_val[p] = acc[p][T-1:0];
            end
            if ((RELU != 0) && sat_val[p][T-1]) begin
                sat_val[p] = '0;
            end
        end
    end

    // Datapath. In EMIT the first cycle only loads data_out/m_valid from the
    // result buffer; later buffer entries are loaded as each word is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            k        <= '0;
            g        <= '0;
            e        <= '0;
            m_valid  <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < M; i++) begin
                x_mem[i] <= '0;
            end
            for (int p = 0; p < P; p++) begin
                acc[p]     <= '0;
                out_buf[p] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        x_mem[cnt] <= data_in;
                        if (last_in) begin
                            cnt <= '0;
                            k   <= '0;
                            g   <= '0;
                            for (int p = 0; p < P; p++) begin
                                acc[p] <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    for (int p = 0; p < P; p++) begin
                        acc[p] <= acc[p] + AW'(prod[p]);
                    end
                    k <= last_k ? '0 : k + 1'b1;
                end
                SAT: begin
                    for (int p = 0; p < P; p++) begin
                        out_buf[p] <= sat_val[p];
                    end
                    e <= '0;
                end
                EMIT: begin
                    if (!m_valid) begin
                        m_valid  <= 1'b1;
                        data_out <= out_buf[e];
                    end else if (m_ready) begin
                        if (last_e) begin
                            m_valid <= 1'b0;
                            e       <= '0;
                            if (last_g) begin
                                g <= '0;
                            end else begin
                                g <= g + 1'b1;
                                k <= '0;
                                for (int p = 0; p < P; p++) begin
                                    acc[p] <= '0;
                                end
                            end
                        end else begin
                            e        <= e + 1'b1;
                            data_out <= out_buf[e + 1'b1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_stream.sv
`timescale 1ns/1ps
// Testbench for fc_layer_stream.
// dut_lin / dut_relu: T=8, M=2, N=2, P=1, W={1,2,3,-4}, identity and ReLU.
// dut_big: default sizes (T=16, M=4, N=8, P=2, ReLU) with a generated weight table.
module tb_fc_layer_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       s_valid_s, m_ready_s;
    logic [7:0] data_in_s;
    logic       m_valid_l, s_ready_l;
    logic [7:0] data_out_l;
    logic       m_valid_r, s_ready_r;
    logic [7:0] data_out_r;

    logic        s_valid_b, m_ready_b;
    logic [15:0] data_in_b;
    logic        m_valid_b, s_ready_b;
    logic [15:0] data_out_b;

    int checks = 0;
    int errors = 0;
    int mr_mode = 0;

    logic [7:0]  q_lin  [$];
    logic [7:0]  q_relu [$];
    logic [15:0] q_big  [$];

    typedef struct {
        logic [7:0] x0;
        logic [7:0] x1;
        logic [7:0] l0;
        logic [7:0] l1;
        logic [7:0] r0;
        logic [7:0] r1;
    } vec_t;

    vec_t tbl [6];

    function automatic logic signed [15:0] big_w(input int i);
        return 16'(((i * 37 + 11) % 127) - 63);
    endfunction

    function automatic logic [511:0] big_w_init();
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            v[i*16 +: 16] = big_w(i);
        end
        return v;
    endfunction

    localparam logic [511:0] BIG_W   = big_w_init();
    localparam logic [31:0]  SMALL_W = {8'hFC, 8'h03, 8'h02, 8'h01};

    fc_layer_stream #(.T(8), .M(2), .N(2), .P(1), .RELU(0), .W_INIT(SMALL_W)) dut_lin (
        .clk(clk), .reset(reset), .s_valid(s_valid_s), .m_ready(m_ready_s),
        .data_in(data_in_s), .m_valid(m_valid_l), .s_ready(s_ready_l), .data_out(data_out_l)
    );

    fc_layer_stream #(.T(8), .M(2), .N(2), .P(1), .RELU(1), .W_INIT(SMALL_W)) dut_relu (
        .clk(clk), .reset(reset), .s_valid(s_valid_s), .m_ready(m_ready_s),
        .data_in(data_in_s), .m_valid(m_valid_r), .s_ready(s_ready_r), .data_out(data_out_r)
    );

    fc_layer_stream #(.W_INIT(BIG_W)) dut_big (
        .clk(clk), .reset(reset), .s_valid(s_valid_b), .m_ready(m_ready_b),
        .data_in(data_in_b), .m_valid(m_valid_b), .s_ready(s_ready_b), .data_out(data_out_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Downstream ready for the big instance: 0 = always ready, 1 = random, 2 = held low.
    always @(posedge clk) begin
        #2;
        case (mr_mode)
            0:       m_ready_b = 1'b1;
            1:       m_ready_b = 1'($urandom_range(0, 1));
            default: m_ready_b = 1'b0;
        endcase
    end

    // Scoreboard: every word that will transfer on the next edge is compared.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid_l === 1'b1 && m_ready_s === 1'b1) begin
                if (q_lin.size() == 0) failNow("lin unexpected output");
                else checkOutput("lin out", 32'(data_out_l), 32'(q_lin.pop_front()));
            end
            if (m_valid_r === 1'b1 && m_ready_s === 1'b1) begin
                if (q_relu.size() == 0) failNow("relu unexpected output");
                else checkOutput("relu out", 32'(data_out_r), 32'(q_relu.pop_front()));
            end
            if (m_valid_b === 1'b1 && m_ready_b === 1'b1) begin
                if (q_big.size() == 0) failNow("big unexpected output");
                else checkOutput("big out", 32'(data_out_b), 32'(q_big.pop_front()));
            end
        end
    end

    task automatic driveSmallWord(input logic [7:0] x);
        logic ok;
        ok = 1'b0;
        s_valid_s = 1'b1;
        data_in_s = x;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            ok = s_valid_s && s_ready_l && s_ready_r;
            @(posedge clk);
            #1;
        end
        s_valid_s = 1'b0;
        if (!ok) failNow("small input accept timeout");
    endtask

    task automatic driveBigWord(input logic [15:0] x, input bit randv);
        logic ok;
        ok = 1'b0;
        data_in_b = x;
        for (int c = 0; c < 2000 && !ok; c++) begin
            s_valid_b = randv ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            ok = s_valid_b && s_ready_b;
            @(posedge clk);
            #1;
        end
        s_valid_b = 1'b0;
        if (!ok) failNow("big input accept timeout");
    endtask

    task automatic applyStimulus(input vec_t v);
        q_lin.push_back(v.l0);
        q_lin.push_back(v.l1);
        q_relu.push_back(v.r0);
        q_relu.push_back(v.r1);
        driveSmallWord(v.x0);
        driveSmallWord(v.x1);
    endtask

    // Golden model for the big instance: full-precision dot product, clip, ReLU.
    task automatic pushBigExpected(input logic [63:0] xv);
        for (int n = 0; n < 8; n++) begin
            longint s;
            s = 0;
            for (int m = 0; m < 4; m++) begin
                s += longint'($signed(xv[m*16 +: 16])) * longint'(big_w(n * 4 + m));
            end
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (s < 0) s = 0;
            q_big.push_back(16'(s));
        end
    endtask

    task automatic sendBig(input logic [63:0] xv, input bit randv);
        pushBigExpected(xv);
        for (int m = 0; m < 4; m++) begin
            driveBigWord(xv[m*16 +: 16], randv);
        end
    endtask

    task automatic drainAll();
        for (int c = 0; c < 20000 && (q_lin.size() + q_relu.size() + q_big.size()) != 0; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("lin drained", 32'(q_lin.size()), 32'd0);
        checkOutput("relu drained", 32'(q_relu.size()), 32'd0);
        checkOutput("big drained", 32'(q_big.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] xv;
        logic [15:0] cap;
        int lat;

        tbl[0] = '{8'd5,      8'd6,      8'd17,     8'(-9),    8'd17,  8'd0};
        tbl[1] = '{8'd100,    8'd100,    8'd127,    8'(-100),  8'd127, 8'd0};
        tbl[2] = '{8'(-100),  8'd100,    8'd100,    8'(-128),  8'd100, 8'd0};
        tbl[3] = '{8'(-50),   8'(-20),   8'(-90),   8'(-70),   8'd0,   8'd0};
        tbl[4] = '{8'd127,    8'(-128),  8'(-128),  8'd127,    8'd0,   8'd127};
        tbl[5] = '{8'd1,      8'(-1),    8'(-1),    8'd7,      8'd0,   8'd7};

        reset     = 1'b1;
        s_valid_s = 1'b0;
        s_valid_b = 1'b0;
        m_ready_s = 1'b1;
        m_ready_b = 1'b1;
        data_in_s = '0;
        data_in_b = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset m_valid lin", 32'(m_valid_l), 32'd0);
        checkOutput("reset s_ready lin", 32'(s_ready_l), 32'd0);
        checkOutput("reset data_out lin", 32'(data_out_l), 32'd0);
        checkOutput("reset m_valid big", 32'(m_valid_b), 32'd0);
        checkOutput("reset s_ready big", 32'(s_ready_b), 32'd0);
        checkOutput("reset data_out big", 32'(data_out_b), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post-reset s_ready lin", 32'(s_ready_l), 32'd1);
        checkOutput("post-reset s_ready relu", 32'(s_ready_r), 32'd1);
        checkOutput("post-reset s_ready big", 32'(s_ready_b), 32'd1);
        @(posedge clk);
        #1;

        // Latency: first m_valid M+2 = 4 edges after the last accepted word.
        q_lin.push_back(8'd17);
        q_lin.push_back(8'(-9));
        q_relu.push_back(8'd17);
        q_relu.push_back(8'd0);
        driveSmallWord(8'd5);
        driveSmallWord(8'd6);
        lat = 0;
        for (int c = 0; c < 20 && m_valid_l !== 1'b1; c++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("first m_valid latency", 32'(lat), 32'd4);
        checkOutput("s_ready low in EMIT", 32'(s_ready_l), 32'd0);
        drainAll();

        // Table-driven vectors, back to back.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i]);
        end
        drainAll();

        // Big instance: plain vectors, including ones that saturate.
        sendBig({16'd300, 16'(-200), 16'd100, 16'd50}, 1'b0);
        sendBig({16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF}, 1'b0);
        drainAll();

        // Backpressure: m_ready held low for 10 cycles while in EMIT.
        mr_mode = 2;
        @(posedge clk);
        #1;
        sendBig({16'(-7), 16'd250, 16'(-120), 16'd99}, 1'b0);
        for (int c = 0; c < 100 && m_valid_b !== 1'b1; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp m_valid rise", 32'(m_valid_b), 32'd1);
        checkOutput("bp first word", 32'(data_out_b), 32'(q_big[0]));
        cap = data_out_b;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp data hold", 32'(data_out_b), 32'(cap));
            checkOutput("bp valid hold", 32'(m_valid_b), 32'd1);
            checkOutput("bp s_ready low", 32'(s_ready_b), 32'd0);
        end
        mr_mode = 0;
        drainAll();

        // Reset during group 1 MAC: E0 accept, E1-4 MAC, E5 SAT, E6 valid,
        // E7-8 transfers, E9-12 group 1 MAC.
        sendBig({16'd11, 16'd22, 16'(-33), 16'd44}, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid reset m_valid", 32'(m_valid_b), 32'd0);
        checkOutput("mid reset s_ready", 32'(s_ready_b), 32'd0);
        checkOutput("mid reset pending words", 32'(q_big.size()), 32'd6);
        q_big.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("after reset m_valid", 32'(m_valid_b), 32'd0);
        checkOutput("after reset s_ready", 32'(s_ready_b), 32'd1);
        @(posedge clk);
        #1;
        sendBig({16'd5, 16'(-6), 16'd7, 16'd8}, 1'b0);
        drainAll();

        // Random stream with random s_valid and m_ready.
        mr_mode = 1;
        for (int v = 0; v < 200; v++) begin
            for (int m = 0; m < 4; m++) begin
                xv[m*16 +: 16] = 16'(int'($urandom_range(0, 511)) - 256);
            end
            sendBig(xv, 1'b1);
        end
        drainAll();
        mr_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
